uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receive front-end of the debug UART. Oversamples the asynchronous `i_rx` line, recovers 8N1 frames, and presents each received byte with a one-cycle done strobe. The debug FSM consumes that byte as its command/program-load stream. The block sits between the board RX pin and the debug FSM's `i_rx_data` / `i_rx_done` inputs, inside the UART wrapper.

Parameters:
- UART_BITS, 8, data bits per frame (LSB first).
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 19200, line baud rate.
- OVERSAMPLE, 16, sample ticks per bit period.
- TICK_DIV, CLK_FREQ/(BAUD_RATE*OVERSAMPLE) (floor; 162 at defaults), clocks per sample tick; must be ≥ 2.

Ports:
- clk  in  1  system clock; all logic rises on posedge.
- rst  in  1  synchronous, active-low reset.
- i_rx  in  1  asynchronous serial line; idle high.
- o_rx_data  out  UART_BITS  last correctly framed byte.
- o_rx_done  out  1  one-cycle strobe: o_rx_data updated this cycle.
- o_rx_frame_err  out  1  one-cycle strobe: stop bit sampled low, byte discarded.

Behaviour:
- Reset (rst==0 at posedge) forces the following state:
  - state=IDLE, tick counter=0, sample count=0, bit index=0, shift register=0.
  - Both synchronizer flops = 1.
  - o_rx_data=0, o_rx_done=0, o_rx_frame_err=0.
- Reset mid-frame aborts the frame. No done or error strobe is produced.
- Synchronizer: 2-flop chain on i_rx. The FSM sees only `rx_s` (2-cycle latency).
- Tick generator: free-running counter 0..TICK_DIV-1.
  - `tick` is high for one clk when count==TICK_DIV-1, then the counter wraps to 0.
  - It never pauses and is independent of FSM state.
- FSM samples `rx_s` only on cycles where `tick`==1. Sample count `s` has width clog2(OVERSAMPLE).
  - IDLE: on rx_s==0 → START, s=0. This is evaluated every clk, not only on ticks.
  - START: on tick, if s==OVERSAMPLE/2-1 (mid start bit):
    - rx_s==0 → DATA, s=0, bit index n=0.
    - rx_s==1 → glitch, return to IDLE with no strobe.
    - Otherwise s++.
  - DATA: on tick, if s==OVERSAMPLE-1: shift = {rx_s, shift[UART_BITS-1:1]}, s=0.
    - If n==UART_BITS-1 → STOP, else n++.
    - Otherwise s++.
  - STOP: on tick, if s==OVERSAMPLE-1:
    - rx_s==1 → o_rx_data<=shift and o_rx_done<=1 for exactly the next cycle; → IDLE.
    - rx_s==0 → o_rx_frame_err<=1 for one cycle, o_rx_data unchanged; → BREAK.
  - BREAK: wait for rx_s==1, then → IDLE. This prevents a held-low line (break) from producing repeated frames.
- o_rx_done and o_rx_frame_err are never both high, and are never high for two consecutive cycles.
- o_rx_data holds its value until the next valid frame.
- Latency from the i_rx falling edge to o_rx_done is about (1.5 + UART_BITS) × OVERSAMPLE × TICK_DIV clocks, plus up to TICK_DIV clocks of tick phase, plus 3 clocks.
- Back-to-back frames: a start bit immediately after the stop sample is detected. IDLE is re-entered with half a bit of stop time remaining.
- No flow control. The consumer must accept each o_rx_done strobe in the cycle it occurs. A new byte overwrites o_rx_data.

Decomposition:
- Shared constants header (existing constants.vh): UART_BITS, CLK_FREQ, BAUD_RATE, OVERSAMPLE, and FSM state encodings.
  - State encodings: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4; 3 bits.
- One sub-module: `baud_tick_gen`.
  - Parameter: TICK_DIV.
  - Ports: clk, rst, o_tick.
  - The UART transmitter reuses it.

Test Plan:
All scenarios use bench parameters CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16, giving TICK_DIV=10 and bit=160 clks.
- Single frame: send 0xA5 (8N1, LSB first) after idle → exactly one o_rx_done pulse about 1520 clks after the start edge; o_rx_data=0xA5; o_rx_frame_err stays 0.
- Back-to-back: send 0x00, 0xFF, 0x3C with no idle gap → three done pulses, data 0x00/0xFF/0x3C in order, each about 1600 clks apart.
- Glitch: drive i_rx low for 40 clks, then high → FSM returns to IDLE; no done or error; a following 0x55 frame is received correctly.
- Framing error: send 0x81 with stop bit 0, then hold low for 2000 clks, then release → one o_rx_frame_err pulse, no done, o_rx_data keeps its previous value, no further strobes while low; a next frame 0x7E gives done with 0x7E.
- Reset mid-frame: assert rst=0 for 3 clks during data bit 4 of 0xC3 → all outputs 0, no strobe; a next full frame 0x12 gives done with 0x12.
- Baud tolerance: send 0x96 at bit period 152 and at 168 clks (±5%) → both received as 0x96 with no frame error.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared constants and state encoding for the debug UART receive path.
// The transmitter side pulls its defaults from here too.
package uart_rx_pkg;

  localparam int UART_BITS  = 8;
  localparam int CLK_FREQ   = 50000000;
  localparam int BAUD_RATE  = 19200;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, rounded down.
  function automatic int tickDiv(input int clkFreq, input int baudRate, input int oversample);
    return clkFreq / (baudRate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received byte and strobes out.
// master = receiver, slave = pin driver / byte consumer.
interface uart_rx_if #(
  parameter int UART_BITS = uart_rx_pkg::UART_BITS
);
  logic                 i_rx;
  logic [UART_BITS-1:0] o_rx_data;
  logic                 o_rx_done;
  logic                 o_rx_frame_err;

  modport master (input i_rx, output o_rx_data, output o_rx_done, output o_rx_frame_err);
  modport slave  (output i_rx, input o_rx_data, input o_rx_done, input o_rx_frame_err);
endinterface

// File: rtl/uart_rx_baud_tick_gen.sv
// Free-running oversample tick: one-clock pulse every TICK_DIV clocks.
// Shared with the UART transmitter, so it never looks at receiver state.
module baud_tick_gen #(
  parameter int TICK_DIV = 162
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (count_q == CNT_LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign o_tick = (count_q == CNT_LAST);
endmodule

// File: rtl/uart_rx.sv
// 8N1 receive front-end: synchronizes the RX pin, oversamples it and
// hands each good byte to the debug FSM with a one-cycle done strobe.
module uart_rx #(
  parameter int UART_BITS  = uart_rx_pkg::UART_BITS,
  parameter int CLK_FREQ   = uart_rx_pkg::CLK_FREQ,
  parameter int BAUD_RATE  = uart_rx_pkg::BAUD_RATE,
  parameter int OVERSAMPLE = uart_rx_pkg::OVERSAMPLE
) (
  input logic        clk,
  input logic        rst,
  uart_rx_if.master  bus
);
  import uart_rx_pkg::*;

  localparam int TICK_DIV = tickDiv(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int NW       = (UART_BITS > 2) ? $clog2(UART_BITS) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(UART_BITS - 1);

  logic                 tick;
  logic                 syncMeta_q;
  logic                 rxSync_q;
  rx_state_e            state_q;
  logic [SW-1:0]        sampleCnt_q;
  logic [NW-1:0]        bitIdx_q;
  logic [UART_BITS-1:0] shift_q;
  logic [UART_BITS-1:0] rxData_q;
  logic                 rxDone_q;
  logic                 frameErr_q;

  baud_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (tick)
  );

  // IDLE reacts on any clock so the start edge is caught with sub-tick resolution;
  // every other state advances only on oversample ticks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      syncMeta_q  <= 1'b1;
      rxSync_q    <= 1'b1;
      state_q     <= IDLE;
      sampleCnt_q <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      rxData_q    <= '0;
      rxDone_q    <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      syncMeta_q <= bus.i_rx;
      rxSync_q   <= syncMeta_q;
      rxDone_q   <= 1'b0;
      frameErr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rxSync_q) begin
            state_q     <= START;
            sampleCnt_q <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (sampleCnt_q == S_MID) begin
              if (!rxSync_q) begin
                state_q     <= DATA;
                sampleCnt_q <= '0;
                bitIdx_q    <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              sampleCnt_q <= sampleCnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sampleCnt_q == S_LAST) begin
              shift_q     <= {rxSync_q, shift_q[UART_BITS-1:1]};
              sampleCnt_q <= '0;
              if (bitIdx_q == N_LAST) begin
                state_q <= STOP;
              end else begin
                bitIdx_q <= bitIdx_q + 1'b1;
              end
            end else begin
              sampleCnt_q <= sampleCnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (sampleCnt_q == S_LAST) begin
              if (rxSync_q) begin
                rxData_q <= shift_q;
                rxDone_q <= 1'b1;
                state_q  <= IDLE;
              end else begin
                frameErr_q <= 1'b1;
                state_q    <= BREAK;
              end
            end else begin
              sampleCnt_q <= sampleCnt_q + 1'b1;
            end
          end
        end
        BREAK: begin
          // A held-low line must return high before another start is accepted.
          if (rxSync_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_rx_data      = rxData_q;
  assign bus.o_rx_done      = rxDone_q;
  assign bus.o_rx_frame_err = frameErr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames at 160 clks/bit and compares every
// strobe against a frame-level model of what the line should deliver.
module tb_uart_rx;
  localparam int BIT_CLKS = 160;
  localparam int LAT_MIN  = 1505;
  localparam int LAT_MAX  = 1545;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  logic [7:0] lastGood;
  logic [7:0] doneData[$];
  int         doneCyc[$];
  int         errCyc[$];
  logic       prevStrobe = 1'b0;

  always #5 clk = ~clk;

  uart_rx_if #(.UART_BITS(8)) rxIf();

  uart_rx #(
    .UART_BITS  (8),
    .CLK_FREQ   (1600000),
    .BAUD_RATE  (10000),
    .OVERSAMPLE (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (rxIf)
  );

  always @(posedge clk) cycle <= cycle + 1;

  // Strobe recorder; also enforces that strobes are exclusive and never back to back.
  always @(negedge clk) begin
    if (rxIf.o_rx_done === 1'b1 || rxIf.o_rx_frame_err === 1'b1) begin
      checks++;
      if (rxIf.o_rx_done === 1'b1 && rxIf.o_rx_frame_err === 1'b1) begin
        failures++;
        $display("[TB] FAIL strobe_exclusive: done=%b err=%b, required not both", rxIf.o_rx_done, rxIf.o_rx_frame_err);
      end
      if (prevStrobe) begin
        failures++;
        $display("[TB] FAIL strobe_width: strobe high again at cycle %0d, required one-cycle pulse", cycle);
      end
      if (rxIf.o_rx_done === 1'b1) begin
        doneData.push_back(rxIf.o_rx_data);
        doneCyc.push_back(cycle);
      end
      if (rxIf.o_rx_frame_err === 1'b1) errCyc.push_back(cycle);
    end
    prevStrobe = (rxIf.o_rx_done === 1'b1) || (rxIf.o_rx_frame_err === 1'b1);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idleLine(input int n);
    rxIf.i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic clearRecords();
    doneData.delete();
    doneCyc.delete();
    errCyc.delete();
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int bitClks, output int startCyc);
    startCyc  = cycle;
    rxIf.i_rx = 1'b0;
    repeat (bitClks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxIf.i_rx = b[i];
      repeat (bitClks) @(negedge clk);
    end
    rxIf.i_rx = stopBit;
    repeat (bitClks) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxIf.i_rx = 1'b1;
    repeat (5) @(negedge clk);
    checks += 3;
    if (rxIf.o_rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %h, required 00", rxIf.o_rx_data); end
    if (rxIf.o_rx_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b, required 0", rxIf.o_rx_done); end
    if (rxIf.o_rx_frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b, required 0", rxIf.o_rx_frame_err); end
    rst = 1'b1;
    lastGood = 8'h00;
    idleLine(50);
  endtask

  task automatic test_single_frame();
    int s;
    int lat;
    clearRecords();
    sendFrame(8'hA5, 1'b1, BIT_CLKS, s);
    idleLine(200);
    lastGood = 8'hA5;
    checks += 4;
    if (doneData.size() != 1) begin failures++; $display("[TB] FAIL single_count: got %0d done, required 1", doneData.size()); end
    else begin
      if (doneData[0] !== 8'hA5) begin failures++; $display("[TB] FAIL single_data: got %h, required a5", doneData[0]); end
      lat = doneCyc[0] - s;
      if (lat < LAT_MIN || lat > LAT_MAX) begin failures++; $display("[TB] FAIL single_latency: got %0d clks, required %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    end
    if (errCyc.size() != 0) begin failures++; $display("[TB] FAIL single_err: got %0d errors, required 0", errCyc.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[3];
    int s;
    bytes = '{8'h00, 8'hFF, 8'h3C};
    clearRecords();
    for (int i = 0; i < 3; i++) sendFrame(bytes[i], 1'b1, BIT_CLKS, s);
    idleLine(200);
    lastGood = 8'h3C;
    checks += 2;
    if (errCyc.size() != 0) begin failures++; $display("[TB] FAIL b2b_err: got %0d errors, required 0", errCyc.size()); end
    if (doneData.size() != 3) begin failures++; $display("[TB] FAIL b2b_count: got %0d done, required 3", doneData.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (doneData[i] !== bytes[i]) begin failures++; $display("[TB] FAIL b2b_data%0d: got %h, required %h", i, doneData[i], bytes[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if ((doneCyc[i] - doneCyc[i-1]) < 10 * BIT_CLKS - 10 || (doneCyc[i] - doneCyc[i-1]) > 10 * BIT_CLKS + 10) begin
          failures++;
          $display("[TB] FAIL b2b_spacing%0d: got %0d clks, required about %0d", i, doneCyc[i] - doneCyc[i-1], 10 * BIT_CLKS);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int s;
    clearRecords();
    rxIf.i_rx = 1'b0;
    repeat (40) @(negedge clk);
    idleLine(300);
    checks += 2;
    if (doneData.size() != 0) begin failures++; $display("[TB] FAIL glitch_done: got %0d done, required 0", doneData.size()); end
    if (errCyc.size() != 0) begin failures++; $display("[TB] FAIL glitch_err: got %0d errors, required 0", errCyc.size()); end
    clearRecords();
    sendFrame(8'h55, 1'b1, BIT_CLKS, s);
    idleLine(200);
    lastGood = 8'h55;
    checks += 2;
    if (doneData.size() != 1) begin failures++; $display("[TB] FAIL glitch_next_count: got %0d done, required 1", doneData.size()); end
    else if (doneData[0] !== 8'h55) begin failures++; $display("[TB] FAIL glitch_next_data: got %h, required 55", doneData[0]); end
    if (rxIf.o_rx_data !== 8'h55) begin failures++; $display("[TB] FAIL glitch_next_hold: got %h, required 55", rxIf.o_rx_data); end
  endtask

  task automatic test_framing_error();
    int s;
    clearRecords();
    sendFrame(8'h81, 1'b0, BIT_CLKS, s);
    repeat (2000) @(negedge clk);
    idleLine(200);
    checks += 3;
    if (errCyc.size() != 1) begin failures++; $display("[TB] FAIL ferr_count: got %0d errors, required 1", errCyc.size()); end
    if (doneData.size() != 0) begin failures++; $display("[TB] FAIL ferr_done: got %0d done, required 0", doneData.size()); end
    if (rxIf.o_rx_data !== lastGood) begin failures++; $display("[TB] FAIL ferr_hold: got %h, required %h", rxIf.o_rx_data, lastGood); end
    clearRecords();
    sendFrame(8'h7E, 1'b1, BIT_CLKS, s);
    idleLine(200);
    lastGood = 8'h7E;
    checks += 2;
    if (doneData.size() != 1) begin failures++; $display("[TB] FAIL ferr_next_count: got %0d done, required 1", doneData.size()); end
    else if (doneData[0] !== 8'h7E) begin failures++; $display("[TB] FAIL ferr_next_data: got %h, required 7e", doneData[0]); end
    if (errCyc.size() != 0) begin failures++; $display("[TB] FAIL ferr_next_err: got %0d errors, required 0", errCyc.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int s;
    b = 8'hC3;
    clearRecords();
    rxIf.i_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxIf.i_rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxIf.i_rx = b[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (rxIf.o_rx_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_data: got %h, required 00", rxIf.o_rx_data); end
    if (rxIf.o_rx_done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_done: got %b, required 0", rxIf.o_rx_done); end
    if (rxIf.o_rx_frame_err !== 1'b0) begin failures++; $display("[TB] FAIL midrst_err: got %b, required 0", rxIf.o_rx_frame_err); end
    rst = 1'b1;
    lastGood = 8'h00;
    idleLine(2000);
    checks += 2;
    if (doneData.size() != 0 || errCyc.size() != 0) begin
      failures++;
      $display("[TB] FAIL midrst_strobe: got %0d done %0d err, required none", doneData.size(), errCyc.size());
    end
    if (rxIf.o_rx_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_hold: got %h, required 00", rxIf.o_rx_data); end
    clearRecords();
    sendFrame(8'h12, 1'b1, BIT_CLKS, s);
    idleLine(200);
    lastGood = 8'h12;
    checks++;
    if (doneData.size() != 1 || doneData[0] !== 8'h12) begin
      failures++;
      $display("[TB] FAIL midrst_next: got %0d done (first %h), required one with 12", doneData.size(), (doneData.size() > 0) ? doneData[0] : 8'hxx);
    end
  endtask

  task automatic test_baud_tolerance();
    int periods[2];
    int s;
    periods = '{152, 168};
    for (int p = 0; p < 2; p++) begin
      clearRecords();
      sendFrame(8'h96, 1'b1, periods[p], s);
      idleLine(300);
      lastGood = 8'h96;
      checks += 2;
      if (doneData.size() != 1 || doneData[0] !== 8'h96) begin
        failures++;
        $display("[TB] FAIL baud%0d_data: got %0d done (first %h), required one with 96", periods[p], doneData.size(), (doneData.size() > 0) ? doneData[0] : 8'hxx);
      end
      if (errCyc.size() != 0) begin failures++; $display("[TB] FAIL baud%0d_err: got %0d errors, required 0", periods[p], errCyc.size()); end
    end
  endtask

  // Model: a frame with a high stop bit delivers its byte; a low stop bit
  // reports one framing error and leaves the last good byte in place.
  task automatic test_random();
    logic [7:0] b;
    logic       stopBit;
    int         s;
    int         expDone;
    for (int f = 0; f < 8; f++) begin
      b       = 8'($urandom_range(0, 255));
      stopBit = ($urandom_range(0, 3) != 0);
      idleLine($urandom_range(0, 200));
      clearRecords();
      sendFrame(b, stopBit, BIT_CLKS, s);
      if (!stopBit) repeat ($urandom_range(0, 500)) @(negedge clk);
      idleLine(300);
      expDone = stopBit ? 1 : 0;
      if (stopBit) lastGood = b;
      checks += 3;
      if (doneData.size() != expDone) begin failures++; $display("[TB] FAIL rand%0d_done: got %0d done, required %0d (byte %h stop %b)", f, doneData.size(), expDone, b, stopBit); end
      if (errCyc.size() != 1 - expDone) begin failures++; $display("[TB] FAIL rand%0d_err: got %0d errors, required %0d", f, errCyc.size(), 1 - expDone); end
      if (rxIf.o_rx_data !== lastGood) begin failures++; $display("[TB] FAIL rand%0d_data: got %h, required %h", f, rxIf.o_rx_data, lastGood); end
    end
  endtask

  initial begin
    rst = 1'b0;
    rxIf.i_rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_reset_mid_frame();
    test_baud_tolerance();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
